break_count_selector: RTL

//   Consumes the per-clause break vectors from the clause evaluator cluster and

---
 rtl/break_count_selector.sv | 132 +++++++++++++
 1 files changed

// File: rtl/break_count_selector.sv
// rtl/break_count_selector.sv - per-candidate break-count accumulator and minimum-break selector
// Counts masked break flags across beats for NSAT candidates, then reports the lowest-count candidate.
module break_count_selector #(
    parameter int CLUSTER_SIZE = 20,
    parameter int NSAT         = 3,
    parameter int COUNT_W      = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [CLUSTER_SIZE-1:0]  break_i,
    input  logic [CLUSTER_SIZE-1:0]  break_mask_i,
    input  logic                     beat_valid_i,
    input  logic                     beat_last_i,
    output logic                     beat_ready_o,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [$clog2(NSAT)-1:0]  sel_cand_o,
    output logic [COUNT_W-1:0]       sel_break_o,
    output logic                     zero_break_o
);

    localparam int POP_W  = $clog2(CLUSTER_SIZE + 1);
    localparam int SUM_W  = ((COUNT_W > POP_W) ? COUNT_W : POP_W) + 1;
    localparam int CAND_W = $clog2(NSAT);
    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CAND_W-1:0]  LAST_CAND = CAND_W'(NSAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [COUNT_W-1:0]  acc;
    logic [COUNT_W-1:0]  acc_final;
    logic [COUNT_W-1:0]  best_cnt;
    logic [CAND_W-1:0]   cand_cnt;
    logic [CAND_W-1:0]   best_idx;
    logic [POP_W-1:0]    inc;
    logic [SUM_W-1:0]    sum;
    logic                beat_fire;
    logic                clause_start;

    always_comb begin
        inc = '0;
        for (int i = 0; i < CLUSTER_SIZE; i++) begin
            inc = inc + POP_W'(break_i[i] & break_mask_i[i]);
        end
    end

    // Sum is one bit wider than either operand so the overflow is visible before clamping.
    always_comb begin
        sum       = SUM_W'(acc) + SUM_W'(inc);
        acc_final = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[COUNT_W-1:0];
    end

    assign beat_fire    = (state == ACCUM) && beat_valid_i;
    assign clause_start = (state == IDLE) || ((state == DONE) && result_ready_i);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = ACCUM;
            ACCUM: begin
                if (beat_fire && beat_last_i && (cand_cnt == LAST_CAND)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (result_ready_i) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        beat_ready_o   = 1'b0;
        result_valid_o = 1'b0;
        sel_cand_o     = '0;
        sel_break_o    = '0;
        zero_break_o   = 1'b0;
        case (state)
            ACCUM: beat_ready_o = 1'b1;
            DONE: begin
                result_valid_o = 1'b1;
                sel_cand_o     = best_idx;
                sel_break_o    = best_cnt;
                zero_break_o   = (best_cnt == '0);
            end
            default: ;
        endcase
    end

    // Candidate 0 always loads best; later ones replace it only on a strictly smaller count.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc      <= '0;
            cand_cnt <= '0;
            best_cnt <= '0;
            best_idx <= '0;
        end else if (clause_start) begin
            acc      <= '0;
            cand_cnt <= '0;
            best_cnt <= CNT_MAX;
            best_idx <= '0;
        end else if (beat_fire) begin
            if (beat_last_i) begin
                acc      <= '0;
                cand_cnt <= cand_cnt + CAND_W'(1);
                if ((cand_cnt == '0) || (acc_final < best_cnt)) begin
                    best_cnt <= acc_final;
                    best_idx <= cand_cnt;
                end
            end else begin
                acc <= acc_final;
            end
        end
    end

endmodule
